// File: rtl/wb_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter_pkg
// Purpose  : Shared widths, constants and the queued-result entry type for
//            the register-file write-port arbiter.
// Revision : 1.0  initial release
// ============================================================================
package wb_port_arbiter_pkg;

  localparam int          c_REG_ADDR_W   = 5;
  localparam int          c_REG_W        = 32;
  localparam logic [4:0]  c_NOP_REG_ADDR = 5'd0;
  localparam logic [31:0] c_ZERO_WORD    = 32'h0;
  localparam logic        c_WRITE_ENABLE  = 1'b1;
  localparam logic        c_WRITE_DISABLE = 1'b0;
  // Reset level for the active-low reset input.
  localparam logic        c_RST_ENABLE_N = 1'b0;

  // One queued long-latency result; live=0 means a younger pipeline write
  // already targeted the same register, so this result must never land.
  typedef struct packed {
    logic                    live;
    logic [c_REG_ADDR_W-1:0] addr;
    logic [c_REG_W-1:0]      data;
  } wb_entry_t;

endpackage : wb_port_arbiter_pkg
`default_nettype wire

// File: rtl/wb_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_result_fifo
// Purpose  : Two-entry in-order queue of long-latency unit results with a
//            per-entry live bit and kill-by-destination-address.
// Revision : 1.0  initial release
// ============================================================================
module wb_result_fifo
  import wb_port_arbiter_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_push,
  input  logic [c_REG_ADDR_W-1:0] i_push_addr,
  input  logic [c_REG_W-1:0]      i_push_data,
  input  logic                    i_pop,
  input  logic                    i_kill,
  input  logic [c_REG_ADDR_W-1:0] i_kill_addr,
  output logic                    o_head_valid,
  output logic                    o_head_live,
  output logic [c_REG_ADDR_W-1:0] o_head_addr,
  output logic [c_REG_W-1:0]      o_head_data,
  output logic                    o_full_next
);

  // Slot 0 is always the head; slot 1 is only valid when slot 0 is.
  logic [1:0]      r_valid;
  wb_entry_t [1:0] r_entry;
  logic [1:0]      w_valid;
  wb_entry_t [1:0] w_entry;
  wb_entry_t       w_new;

  assign o_head_valid = r_valid[0];
  assign o_head_live  = r_valid[0] & r_entry[0].live;
  assign o_head_addr  = r_entry[0].addr;
  assign o_head_data  = r_entry[0].data;
  assign o_full_next  = &w_valid;

  // Next queue contents: kill stored entries, shift on pop, then append.
  always_comb begin
    w_valid    = r_valid;
    w_entry    = r_entry;
    w_new.live = !(i_kill && (i_push_addr == i_kill_addr));
    w_new.addr = i_push_addr;
    w_new.data = i_push_data;
    for (int i = 0; i < 2; i++) begin
      if (i_kill && (w_entry[i].addr == i_kill_addr)) begin
        w_entry[i].live = 1'b0;
      end
    end
    if (i_pop) begin
      w_valid    = {1'b0, w_valid[1]};
      w_entry[0] = w_entry[1];
    end
    if (i_push) begin
      if (!w_valid[0]) begin
        w_valid[0] = 1'b1;
        w_entry[0] = w_new;
      end else begin
        w_valid[1] = 1'b1;
        w_entry[1] = w_new;
      end
    end
  end

  // Queue storage; reset empties the queue and discards pending results.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == c_RST_ENABLE_N) begin
      r_valid <= 2'b00;
      r_entry <= '0;
    end else begin
      r_valid <= w_valid;
      r_entry <= w_entry;
    end
  end

endmodule : wb_result_fifo
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter
// Purpose  : Shares the register-file write port between the MEM/WB pipeline
//            (always wins) and queued long-latency unit results, raising a
//            stall request when the queue head is starved.
// Revision : 1.0  initial release
// ============================================================================
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wb_wreg,
  input  logic [c_REG_ADDR_W-1:0] wb_wd,
  input  logic [c_REG_W-1:0]      wb_wdata,
  input  logic                    lu_valid,
  input  logic [c_REG_ADDR_W-1:0] lu_wd,
  input  logic [c_REG_W-1:0]      lu_wdata,
  output logic                    lu_ready,
  output logic                    rf_we,
  output logic [c_REG_ADDR_W-1:0] rf_waddr,
  output logic [c_REG_W-1:0]      rf_wdata,
  output logic                    stallreq
);

  localparam logic [3:0] c_SC_MAX = 4'(STARVE_MAX);

  logic                    w_in_reset;
  logic                    w_pipe_grant;
  logic                    w_q_grant;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_head_valid;
  logic                    w_head_live;
  logic [c_REG_ADDR_W-1:0] w_head_addr;
  logic [c_REG_W-1:0]      w_head_data;
  logic                    w_full_next;
  logic [3:0]              w_sc_next;
  logic [3:0]              r_sc;
  logic                    r_lu_ready;
  logic                    r_stallreq;

  assign w_in_reset   = (rst == c_RST_ENABLE_N);
  // r0 writes are dropped, so they neither take the port nor kill entries.
  assign w_pipe_grant = !w_in_reset && wb_wreg && (wb_wd != c_NOP_REG_ADDR);
  assign w_q_grant    = !w_in_reset && !w_pipe_grant && w_head_live;
  // Dead heads leave without using the port.
  assign w_pop        = w_head_valid && (!w_head_live || w_q_grant);
  // r0 results are accepted from the unit but never stored.
  assign w_push       = lu_valid && r_lu_ready && (lu_wd != c_NOP_REG_ADDR);

  assign lu_ready = r_lu_ready;
  assign stallreq = r_stallreq;

  wb_result_fifo u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_push),
    .i_push_addr  (lu_wd),
    .i_push_data  (lu_wdata),
    .i_pop        (w_pop),
    .i_kill       (w_pipe_grant),
    .i_kill_addr  (wb_wd),
    .o_head_valid (w_head_valid),
    .o_head_live  (w_head_live),
    .o_head_addr  (w_head_addr),
    .o_head_data  (w_head_data),
    .o_full_next  (w_full_next)
  );

  // Write-port mux: pipeline first, then a live queue head, else idle zeros.
  always_comb begin
    rf_we    = c_WRITE_DISABLE;
    rf_waddr = c_NOP_REG_ADDR;
    rf_wdata = c_ZERO_WORD;
    if (w_pipe_grant) begin
      rf_we    = c_WRITE_ENABLE;
      rf_waddr = wb_wd;
      rf_wdata = wb_wdata;
    end else if (w_q_grant) begin
      rf_we    = c_WRITE_ENABLE;
      rf_waddr = w_head_addr;
      rf_wdata = w_head_data;
    end
  end

  // Starvation count: grows while a live head is denied, saturating.
  always_comb begin
    w_sc_next = 4'd0;
    if (w_head_live && !w_q_grant) begin
      w_sc_next = (r_sc >= c_SC_MAX) ? c_SC_MAX : r_sc + 4'd1;
    end
  end

  // Registered status: starvation count, stall request and queue-ready.
  // The stall request also drops once no live head remains, so a head that
  // gets killed while starved cannot leave the pipeline stalled forever.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == c_RST_ENABLE_N) begin
      r_sc       <= 4'd0;
      r_stallreq <= 1'b0;
      r_lu_ready <= 1'b0;
    end else begin
      r_sc       <= w_sc_next;
      r_lu_ready <= !w_full_next;
      if (w_q_grant || !w_head_live) begin
        r_stallreq <= 1'b0;
      end else if (w_sc_next == c_SC_MAX) begin
        r_stallreq <= 1'b1;
      end
    end
  end

endmodule : wb_port_arbiter
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_port_arbiter
// Purpose  : Directed self-checking bench for wb_port_arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_wreg;
  logic [4:0]  wb_wd;
  logic [31:0] wb_wdata;
  logic        lu_valid;
  logic [4:0]  lu_wd;
  logic [31:0] lu_wdata;
  logic        lu_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        stallreq;

  int checks = 0;
  int errors = 0;
  logic [37:0] e;

  wb_port_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .wb_wreg(wb_wreg), .wb_wd(wb_wd), .wb_wdata(wb_wdata),
    .lu_valid(lu_valid), .lu_wd(lu_wd), .lu_wdata(lu_wdata),
    .lu_ready(lu_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .stallreq(stallreq)
  );

  always #5 clk = ~clk;

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pw, input logic [4:0] pd, input logic [31:0] pdat,
                       input logic lv, input logic [4:0] ld, input logic [31:0] ldat);
    wb_wreg = pw; wb_wd = pd; wb_wdata = pdat;
    lu_valid = lv; lu_wd = ld; lu_wdata = ldat;
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    checks++; if ({rf_we, lu_ready, stallreq} !== 3'b000) begin
      errors++; $display("FAIL reset_outputs: got %b expected 000", {rf_we, lu_ready, stallreq});
    end
    rst = 1'b1; #1;
    checks++; if (lu_ready !== 1'b0) begin
      errors++; $display("FAIL reset_release_ready: got %b expected 0", lu_ready);
    end
    tick();
    checks++; if (lu_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready_after_edge: got %b expected 1", lu_ready);
    end
  endtask

  task automatic test_priority();
    drive(1'b1, 5'd5, 32'h11, 1'b1, 5'd8, 32'h22);
    e = {1'b1, 5'd5, 32'h11};
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== e) begin
      errors++; $display("FAIL prio_pipe: got %h expected %h", {rf_we, rf_waddr, rf_wdata}, e);
    end
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    e = {1'b1, 5'd8, 32'h22};
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== e) begin
      errors++; $display("FAIL prio_queue: got %h expected %h", {rf_we, rf_waddr, rf_wdata}, e);
    end
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checks++; if ({rf_we, rf_waddr, rf_wdata, lu_ready} !== {38'h0, 1'b1}) begin
      errors++; $display("FAIL prio_idle: got %h expected %h", {rf_we, rf_waddr, rf_wdata, lu_ready}, {38'h0, 1'b1});
    end
  endtask

  task automatic test_full();
    logic [3:0] exp_ready = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      tick();
      drive(1'b1, 5'd1, 32'h100 + i, 1'b1, 5'd10 + 5'(i < 2 ? i : 2), 32'hA0 + 32'(i < 2 ? i : 2));
      e = {1'b1, 5'd1, 32'h100 + 32'(i)};
      checks++; if ({rf_we, rf_waddr, rf_wdata} !== e || lu_ready !== exp_ready[i]) begin
        errors++; $display("FAIL full_fill[%0d]: got %h/%b expected %h/%b", i, {rf_we, rf_waddr, rf_wdata}, lu_ready, e, exp_ready[i]);
      end
    end
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'hA2);
    e = {1'b1, 5'd10, 32'hA0};
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== e || lu_ready !== 1'b0 || stallreq !== 1'b0) begin
      errors++; $display("FAIL full_drain0: got %h/%b/%b expected %h/0/0", {rf_we, rf_waddr, rf_wdata}, lu_ready, stallreq, e);
    end
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'hA2);
    e = {1'b1, 5'd11, 32'hA1};
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== e || lu_ready !== 1'b1) begin
      errors++; $display("FAIL full_drain1: got %h/%b expected %h/1", {rf_we, rf_waddr, rf_wdata}, lu_ready, e);
    end
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    e = {1'b1, 5'd12, 32'hA2};
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== e) begin
      errors++; $display("FAIL full_drain2: got %h expected %h", {rf_we, rf_waddr, rf_wdata}, e);
    end
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== 38'h0) begin
      errors++; $display("FAIL full_empty: got %h expected 0", {rf_we, rf_waddr, rf_wdata});
    end
  endtask

  task automatic test_waw();
    tick();
    drive(1'b1, 5'd2, 32'h1, 1'b1, 5'd7, 32'hAA);
    tick();
    drive(1'b1, 5'd7, 32'hBB, 1'b0, 5'd0, 32'h0);
    e = {1'b1, 5'd7, 32'hBB};
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== e) begin
      errors++; $display("FAIL waw_pipe: got %h expected %h", {rf_we, rf_waddr, rf_wdata}, e);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      checks++; if (rf_we !== 1'b0) begin
        errors++; $display("FAIL waw_dead[%0d]: got rf_we=%b addr=%h data=%h expected rf_we=0", i, rf_we, rf_waddr, rf_wdata);
      end
    end
    // same-cycle push and pipeline write to r6: stored dead
    tick();
    drive(1'b1, 5'd6, 32'hDD, 1'b1, 5'd6, 32'hCC);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checks++; if (rf_we !== 1'b0) begin
      errors++; $display("FAIL waw_push_kill: got rf_we=%b data=%h expected rf_we=0", rf_we, rf_wdata);
    end
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checks++; if ({rf_we, lu_ready} !== 2'b01) begin
      errors++; $display("FAIL waw_after: got %b expected 01", {rf_we, lu_ready});
    end
  endtask

  task automatic test_starve();
    tick();
    drive(1'b1, 5'd9, 32'h9, 1'b1, 5'd3, 32'h55);
    for (int c = 1; c <= 5; c++) begin
      tick();
      drive(1'b1, 5'd9, 32'h9, 1'b0, 5'd0, 32'h0);
      checks++; if (stallreq !== (c == 5) || rf_waddr !== 5'd9) begin
        errors++; $display("FAIL starve_c%0d: got stallreq=%b addr=%h expected stallreq=%b addr=09", c, stallreq, rf_waddr, c == 5);
      end
    end
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    e = {1'b1, 5'd3, 32'h55};
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== e || stallreq !== 1'b1) begin
      errors++; $display("FAIL starve_grant: got %h/%b expected %h/1", {rf_we, rf_waddr, rf_wdata}, stallreq, e);
    end
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checks++; if ({rf_we, stallreq} !== 2'b00) begin
      errors++; $display("FAIL starve_clear: got %b expected 00", {rf_we, stallreq});
    end
  endtask

  task automatic test_r0();
    tick();
    drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd4, 32'h44);
    tick();
    drive(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'h0);
    e = {1'b1, 5'd4, 32'h44};
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== e) begin
      errors++; $display("FAIL r0_pipe_drain: got %h expected %h", {rf_we, rf_waddr, rf_wdata}, e);
    end
    tick();
    drive(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'h99);
    checks++; if ({rf_we, rf_waddr, rf_wdata, lu_ready} !== {38'h0, 1'b1}) begin
      errors++; $display("FAIL r0_pipe_drop: got %h expected %h", {rf_we, rf_waddr, rf_wdata, lu_ready}, {38'h0, 1'b1});
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      checks++; if ({rf_we, lu_ready} !== 2'b01) begin
        errors++; $display("FAIL r0_unit_discard[%0d]: got %b expected 01", i, {rf_we, lu_ready});
      end
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    tick();
    drive(1'b1, 5'd9, 32'h9, 1'b1, 5'd20, 32'h1);
    tick();
    drive(1'b1, 5'd9, 32'h9, 1'b1, 5'd21, 32'h2);
    while (stallreq !== 1'b1 && n < 10) begin
      tick();
      drive(1'b1, 5'd9, 32'h9, 1'b0, 5'd0, 32'h0);
      n++;
    end
    checks++; if (stallreq !== 1'b1 || lu_ready !== 1'b0) begin
      errors++; $display("FAIL rstmid_setup: got stallreq=%b lu_ready=%b expected 1/0", stallreq, lu_ready);
    end
    rst = 1'b0; #1;
    checks++; if ({rf_we, rf_waddr, rf_wdata, stallreq, lu_ready} !== 40'h0) begin
      errors++; $display("FAIL rstmid_async: got %h expected 0", {rf_we, rf_waddr, rf_wdata, stallreq, lu_ready});
    end
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    rst = 1'b1; #1;
    checks++; if (lu_ready !== 1'b0) begin
      errors++; $display("FAIL rstmid_release: got lu_ready=%b expected 0", lu_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      checks++; if ({rf_we, lu_ready, stallreq} !== 3'b010) begin
        errors++; $display("FAIL rstmid_no_stale[%0d]: got %b expected 010", i, {rf_we, lu_ready, stallreq});
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    wb_wreg = 1'b0; wb_wd = 5'd0; wb_wdata = 32'h0;
    lu_valid = 1'b0; lu_wd = 5'd0; lu_wdata = 32'h0;
    test_reset();
    test_priority();
    test_full();
    test_waw();
    test_starve();
    test_r0();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_wb_port_arbiter
`default_nettype wire

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port between the in-order MEM/WB pipeline output and a long-latency unit (divider/multiplier) that returns results out of band. Sits between `mem_wb`, the long-latency unit and `regfile`. Pipeline writes always win. Unit results wait in a 2-entry queue, and a starvation counter raises a stall request to `ctrl` so that the pipeline bubbles and a queued result can drain.

## Interface
- `STARVE_MAX`, default 4: consecutive lost cycles of a live queue head before `stallreq` asserts; legal range 1..15.

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset (asserted at 0)
- `wb_wreg`  in  1  pipeline write enable (from `mem_wb`)
- `wb_wd`  in  5  pipeline destination register
- `wb_wdata`  in  32  pipeline write data
- `lu_valid`  in  1  unit result valid
- `lu_wd`  in  5  unit destination register
- `lu_wdata`  in  32  unit result data
- `lu_ready`  out  1  queue can accept; registered; 0 in reset
- `rf_we`  out  1  regfile write enable; combinational; 0 while `rst`=0
- `rf_waddr`  out  5  regfile write address; 0 when `rf_we`=0
- `rf_wdata`  out  32  regfile write data; 0 when `rf_we`=0
- `stallreq`  out  1  bubble request to `ctrl`; registered; 0 in reset

## Operation
- Pipeline grant: `wb_wreg`=1 and `wb_wd`≠0 drive `rf_*` from the `wb_*` inputs. Writes to r0 are dropped, which gives `rf_we`=0 for that source.
- Queue grant: there is no pipeline grant and the queue head is live. `rf_*` is driven from the head, and the head pops at the clock edge.
- Dead head: a killed head pops in any cycle without using the port. The next entry becomes head on the following cycle.
- Push: a unit result is accepted on `lu_valid`&`lu_ready`.
  - `lu_wd`=0 is accepted and discarded (not stored).
- `lu_ready` is `count`<2 from registered state. A full queue that pops this cycle still shows `lu_ready`=0; the unit is not expected to combinationally depend on the pop.
- No bypass: a pushed entry is never written in its push cycle. Its earliest write is the next cycle.
- Kill (WAW): every pipeline grant to register X marks each stored entry with addr X dead. An entry being pushed in the same cycle with `lu_wd`=X is stored dead. Unit results are defined older than the concurrently retiring pipeline instruction.
- Starvation counter `sc`:
  - increments each cycle the head is live and not granted
  - clears on a queue grant, on an empty queue, or on a dead head
  - `stallreq` sets on the edge where `sc` reaches `STARVE_MAX`, and clears on the edge after the head's queue grant
- FIFO order is strict. Entries are never reordered.

## Timing
- Write-port path is combinational and zero-latency for pipeline writes. Minimum queue latency is push→write = 1 cycle.
- Starvation bound:
  - head live at cycle t with the pipeline writing every cycle → `stallreq`=1 from cycle t+`STARVE_MAX`
  - `ctrl` bubbles and `wb_wreg`=0 at cycle b → head written in cycle b
  - `stallreq`=0 from b+1
- Asynchronous reset mid-operation:
  - queue emptied, `sc`=0, `stallreq`=0, `lu_ready`=0
  - `lu_ready` goes to 1 on the first edge after deassertion
  - queued results are lost; the pipeline is flushed by the same reset
- `sc` width is 4 bits and saturates at `STARVE_MAX`.

## Structure
- `defines.v` already provides `RegAddrBus`, `RegBus`, `NOPRegAddr`, `ZeroWord`, `WriteEnable` and `WriteDisable`.
- Add `RstEnable_n` (1'b0) to `defines.v` for the active-low compare.
- One sub-module, `wb_result_fifo`: 2-entry queue with per-entry valid/live bits, a kill-by-address input, and a head/pop/push interface.
- Arbitration and the starvation counter stay in `wb_port_arbiter`.

## Test plan
- Basic priority: `wb_wreg`=1, `wb_wd`=5, data 0x11 while the unit pushes (8, 0x22) → cycle 0 writes r5=0x11; cycle 1 with `wb_wreg`=0 writes r8=0x22.
- Full queue: push 3 results on consecutive cycles with the pipeline writing continuously → `lu_ready` falls after 2 accepts; the third is held; the queue stays full with no data loss.
- WAW kill: queue (7, 0xAA); pipeline writes r7=0xBB → 0xAA is never written, the entry pops with no `rf_we`, and r7 ends at 0xBB.
- Starvation: `STARVE_MAX`=4, queue (3, 0x55), pipeline writing r9 every cycle → `stallreq`=1 four cycles later. Drop `wb_wreg` → r3=0x55 is written and `stallreq` falls the next cycle.
- r0 handling: pipeline `wb_wd`=0 with `wb_wreg`=1 → `rf_we`=0 and the queue head drains that cycle. A unit push with `lu_wd`=0 → accepted, never written.
- Reset: assert `rst`=0 with 2 entries queued and `stallreq`=1 → all outputs are 0 immediately (asynchronous). After release, `lu_ready`=1 one edge later and no stale writes occur.
